// File: rtl/adder_mon_pkg.sv
// Shared types and constants for the approximate-adder error monitor.
// FSM state encoding, LFSR constants and the absolute-difference helper.
package adder_mon_pkg;

    // Monitor FSM states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRIVE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } mon_state_t;

    // Galois taps for x^32 + x^22 + x^2 + x + 1 (right-shifting form).
    localparam logic [31:0] LFSR_POLY    = 32'h8020_0003;
    localparam logic [31:0] DEFAULT_SEED = 32'hACE1_1D5B;

    // Widest sum the monitor supports (16-bit operands plus carry-out).
    localparam int ABS_W = 17;

    // Unsigned |a - b|. Narrower callers zero-extend into ABS_W bits.
    function automatic logic [ABS_W-1:0] abs_diff(input logic [ABS_W-1:0] a,
                                                  input logic [ABS_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/approx_adder_err_monitor_lfsr32.sv
// 32-bit Galois LFSR used as the operand source.
// rst or load copies the seed in; step advances one position.
module lfsr32
    import adder_mon_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        step,
    output logic [31:0] q
);

    // Seed on reset/load, otherwise shift right and fold in the taps when bit 0 falls out.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            q <= seed;
        end else if (step) begin
            q <= {1'b0, q[31:1]} ^ (q[0] ? LFSR_POLY : 32'h0);
        end
    end

endmodule

// File: rtl/approx_adder_err_monitor.sv
// Approximate-adder error monitor: drives LFSR operands to an external
// combinational approximate adder, computes the exact sum and accumulates
// mismatch count, total absolute error and (optionally) maximum absolute error.
// Optional feature macro: ERR_MAX_EN (err_max tracking; tied to 0 when undefined).
//
// Handshake: start is a level sampled only while IDLE (and not in reset); once
// accepted, busy stays high until the DONE cycle inclusive and done pulses for
// exactly one cycle. ax_sum is assumed to follow op_a/op_b/op_cin combinationally.
module approx_adder_err_monitor
    import adder_mon_pkg::*;
#(
    parameter int          WIDTH    = 16,
    parameter int          SAMPLE_W = 14,
    parameter logic [31:0] SEED     = DEFAULT_SEED
)
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [SAMPLE_W-1:0]         n_samples,
    output logic                        busy,
    output logic                        done,
    output logic [WIDTH-1:0]            op_a,
    output logic [WIDTH-1:0]            op_b,
    output logic                        op_cin,
    input  logic [WIDTH:0]              ax_sum,
    output logic [SAMPLE_W-1:0]         err_count,
    output logic [WIDTH+SAMPLE_W:0]     err_total,
    output logic [WIDTH:0]              err_max,
    output mon_state_t                  dbg_state
);

    localparam int SUM_W = WIDTH + 1;
    localparam int TOT_W = WIDTH + 1 + SAMPLE_W;

    mon_state_t          state;
    mon_state_t          state_nxt;

    logic                accept;
    logic                last_sample;
    logic                lfsr_step;
    logic [31:0]         lfsr_q;
    logic [31:0]         op_src;

    logic [SAMPLE_W-1:0] n_lat;
    logic [SAMPLE_W-1:0] cnt;
    logic [SAMPLE_W-1:0] cnt_inc;
    logic [SUM_W-1:0]    exact_q;
    logic [ABS_W-1:0]    err_wide;
    logic [SUM_W-1:0]    err;

    assign dbg_state = state;
    assign cnt_inc   = cnt + SAMPLE_W'(1);
    assign err_wide  = abs_diff(ABS_W'(exact_q), ABS_W'(ax_sum));
    assign err       = err_wide[SUM_W-1:0];

    // The first sample's operands come straight from SEED, since the LFSR is being reloaded on that same edge.
    assign op_src = (state == ST_IDLE) ? SEED : lfsr_q;

    lfsr32 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .seed (SEED),
        .step (lfsr_step),
        .q    (lfsr_q)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (n_samples == '0) ? ST_DONE : ST_DRIVE;
                end
            end
            ST_DRIVE:   state_nxt = ST_CAPTURE;
            ST_CAPTURE: state_nxt = last_sample ? ST_DONE : ST_DRIVE;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs and datapath strobes.
    always_comb begin
        busy        = (state != ST_IDLE);
        done        = (state == ST_DONE);
        accept      = (state == ST_IDLE) && start;
        lfsr_step   = (state == ST_DRIVE);
        last_sample = (state == ST_CAPTURE) && (cnt_inc == n_lat);
    end

    // Operand, exact-sum, sample-counter and statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            n_lat     <= '0;
            cnt       <= '0;
            exact_q   <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_cin    <= 1'b0;
            err_count <= '0;
            err_total <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        n_lat     <= n_samples;
                        cnt       <= '0;
                        err_count <= '0;
                        err_total <= '0;
                        op_a      <= op_src[WIDTH-1:0];
                        op_b      <= op_src[16+WIDTH-1:16];
                        op_cin    <= ^op_src;
                    end
                end
                ST_DRIVE: begin
                    exact_q <= SUM_W'(op_a) + SUM_W'(op_b) + SUM_W'(op_cin);
                end
                ST_CAPTURE: begin
                    cnt <= cnt_inc;
                    if (err != '0) begin
                        err_count <= err_count + SAMPLE_W'(1);
                        err_total <= err_total + TOT_W'(err);
                    end
                    // Next operands come from the LFSR, which already stepped on leaving DRIVE.
                    if (!last_sample) begin
                        op_a   <= op_src[WIDTH-1:0];
                        op_b   <= op_src[16+WIDTH-1:16];
                        op_cin <= ^op_src;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ERR_MAX_EN
    logic [SUM_W-1:0] err_max_q;

    // Running maximum of the absolute error, cleared on an accepted start.
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            err_max_q <= '0;
        end else if ((state == ST_CAPTURE) && (err > err_max_q)) begin
            err_max_q <= err;
        end
    end

    assign err_max = err_max_q;
`else
    assign err_max = '0;
`endif

endmodule

// File: tb/tb_approx_adder_err_monitor.sv
// Self-checking bench for approx_adder_err_monitor. A behavioural model walks
// the LFSR sequence with plain arithmetic and predicts operands and statistics.
module tb_approx_adder_err_monitor;
    import adder_mon_pkg::*;

    localparam int W  = 16;
    localparam int SW = 14;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              start;
    logic [SW-1:0]     n_samples;
    logic              busy;
    logic              done;
    logic [W-1:0]      op_a;
    logic [W-1:0]      op_b;
    logic              op_cin;
    logic [W:0]        ax_sum;
    logic [SW-1:0]     err_count;
    logic [W+SW:0]     err_total;
    logic [W:0]        err_max;
    mon_state_t        dbg_state;

    int checks   = 0;
    int failures = 0;
    int ax_mode  = 0;

    approx_adder_err_monitor #(.WIDTH(W), .SAMPLE_W(SW), .SEED(32'hACE1_1D5B)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .n_samples (n_samples),
        .busy      (busy),
        .done      (done),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_cin    (op_cin),
        .ax_sum    (ax_sum),
        .err_count (err_count),
        .err_total (err_total),
        .err_max   (err_max),
        .dbg_state (dbg_state)
    );

    // Approximate-adder stand-ins selected by ax_mode.
    function automatic logic [16:0] ax_of(input int a, input int b, input int cin, input int mode);
        int exact;
        exact = a + b + cin;
        case (mode)
            0:       return 17'(exact);
            1:       return 17'(exact) & ~17'h1;
            2:       return 17'(exact) ^ 17'h10000;
            3:       return 17'((a ^ b) + cin);
            default: return 17'(exact + (b % 4));
        endcase
    endfunction

    always_comb ax_sum = ax_of(int'(op_a), int'(op_b), int'(op_cin), ax_mode);

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_b_q[$];
    logic         exp_c_q[$];
    longint       exp_cnt;
    longint       exp_tot;
    longint       exp_max;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: walk the LFSR from SEED, build the operand queues and the statistics.
    task automatic model_run(input int n, input int mode);
        logic [31:0] l;
        int a, b, c, exact, ax, e;
        l = 32'hACE1_1D5B;
        exp_q.delete(); exp_b_q.delete(); exp_c_q.delete();
        exp_cnt = 0; exp_tot = 0; exp_max = 0;
        for (int k = 0; k < n; k++) begin
            a = int'(l[15:0]);
            b = int'(l[31:16]);
            c = int'(^l);
            exp_q.push_back(W'(a));
            exp_b_q.push_back(W'(b));
            exp_c_q.push_back(c[0]);
            exact = a + b + c;
            ax    = int'(ax_of(a, b, c, mode));
            e     = (exact > ax) ? exact - ax : ax - exact;
            if (e != 0) begin
                exp_cnt++;
                exp_tot += e;
            end
            if (e > exp_max) exp_max = e;
            l = (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
        end
`ifndef ERR_MAX_EN
        exp_max = 0;
`endif
    endtask

    task automatic chk_stats(input string tag);
        chk({tag, "_err_count"}, 64'(err_count), 64'(exp_cnt));
        chk({tag, "_err_total"}, 64'(err_total), 64'(exp_tot));
        chk({tag, "_err_max"},   64'(err_max),   64'(exp_max));
    endtask

    // ---------------- driver ----------------
    // One full run: start at edge 0, then check every cycle through 2N+2.
    task automatic run_check(input string tag, input int n, input int mode, input bit spam);
        int last;
        logic [W-1:0] ea, eb;
        logic ec;
        model_run(n, mode);
        last = 2 * n + 1;
        @(negedge clk);
        ax_mode   = mode;
        n_samples = SW'(n);
        start     = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= last; cyc++) begin
            @(negedge clk);
            start = (spam && cyc < last) ? 1'($urandom_range(0, 1)) : 1'b0;
            chk({tag, "_busy"}, 64'(busy), 64'(1));
            chk({tag, "_done"}, 64'(done), 64'(cyc == last));
            if ((cyc % 2 == 1) && cyc < last) begin
                ea = exp_q.pop_front();
                eb = exp_b_q.pop_front();
                ec = exp_c_q.pop_front();
                chk({tag, "_op_a"},   64'(op_a),   64'(ea));
                chk({tag, "_op_b"},   64'(op_b),   64'(eb));
                chk({tag, "_op_cin"}, 64'(op_cin), 64'(ec));
            end
            if (cyc == last) chk_stats({tag, "_final"});
        end
        start = 1'b0;
        @(negedge clk);
        chk({tag, "_busy_off"}, 64'(busy), 64'(0));
        chk({tag, "_done_off"}, 64'(done), 64'(0));
        chk_stats({tag, "_hold"});
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_state"},     64'(dbg_state), 64'(ST_IDLE));
        chk({tag, "_busy"},      64'(busy),      64'(0));
        chk({tag, "_done"},      64'(done),      64'(0));
        chk({tag, "_op_a"},      64'(op_a),      64'(0));
        chk({tag, "_op_b"},      64'(op_b),      64'(0));
        chk({tag, "_op_cin"},    64'(op_cin),    64'(0));
        chk({tag, "_err_count"}, 64'(err_count), 64'(0));
        chk({tag, "_err_total"}, 64'(err_total), 64'(0));
        chk({tag, "_err_max"},   64'(err_max),   64'(0));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1; start = 1'b0; n_samples = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        // Exact adder: no errors expected.
        run_check("exact100", 100, 0, 1'b0);

        // LSB forced to zero: every odd exact sum is off by one.
        run_check("lsb1000", 1000, 1, 1'b0);
        chk("lsb_total_eq_count", 64'(err_total), 64'(err_count));

        // Carry-out flipped: every sample off by 65536.
        run_check("msb10", 10, 2, 1'b0);
        chk("msb_total_const", 64'(err_total), 64'(655360));

        // Zero-sample run: done in cycle 1, statistics cleared.
        run_check("zero", 0, 2, 1'b0);

        // Mid-run reset at cycle 9 of a 20-sample run.
        @(negedge clk);
        ax_mode = 2; n_samples = SW'(20); start = 1'b1;
        @(posedge clk);
        repeat (9) @(negedge clk);
        start = 1'b0;
        chk("abort_busy_c9", 64'(busy), 64'(1));
        chk("abort_count_c9", 64'(err_count), 64'(4));
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("abort");
        // start together with rst must be ignored.
        start = 1'b1;
        @(negedge clk);
        chk("rst_start_busy", 64'(busy), 64'(0));
        rst = 1'b0; start = 1'b0;
        run_check("rerun20", 20, 2, 1'b0);

        // start spammed while busy: no restart, one done at 2N+1.
        run_check("spam15", 15, 0, 1'b1);

        // Randomized runs with bidirectional error adders.
        for (int r = 0; r < 4; r++) begin
            run_check($sformatf("rand%0d", r), int'($urandom_range(1, 40)),
                      int'($urandom_range(3, 4)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/approx_adder_err_monitor.md
# approx_adder_err_monitor

Self-checking controller that sequences an external approximate adder (Brent-Kung/Sklansky-style, combinational) through N pseudo-random operand sets. It computes the exact sum internally, and accumulates error statistics in hardware: mismatch count, total absolute error and maximum absolute error. It sits beside the approximate adder in characterization builds and replaces bench-side error loops, so error metrics can be read from silicon or FPGA.

## Interface
- WIDTH, 16, operand width; legal 4..16
- SAMPLE_W, 14, width of sample counter and mismatch count
- SEED, 32'hACE1_1D5B, LFSR seed; nonzero
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a run; honoured only in IDLE
- n_samples  in  SAMPLE_W  samples per run; sampled on accepted start
- busy  out  1  high from the cycle after accepted start until DONE inclusive
- done  out  1  single-cycle pulse at run end
- op_a, op_b  out  WIDTH  operands to approximate adder
- op_cin  out  1  carry-in to approximate adder
- ax_sum  in  WIDTH+1  approximate adder result (carry-out is MSB)
- err_count  out  SAMPLE_W  samples with nonzero error
- err_total  out  WIDTH+1+SAMPLE_W  sum of absolute errors; cannot overflow
- err_max  out  WIDTH+1  largest absolute error seen

## Operation
- FSM states: IDLE, DRIVE, CAPTURE, DONE.
- IDLE + start:
  - Latch n_samples.
  - Reload LFSR with SEED.
  - Clear all statistics and the sample counter.
  - Go to DRIVE, or to DONE if n_samples==0.
- Operand source: 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1.
  - op_a = lfsr[WIDTH-1:0].
  - op_b = lfsr[16+WIDTH-1:16].
  - op_cin = ^lfsr.
- Operand registers load on entry to DRIVE and hold through CAPTURE. The LFSR advances one step on each DRIVE→CAPTURE transition.
- DRIVE: operands stable; exact sum = op_a+op_b+op_cin is registered, WIDTH+1 bits.
- CAPTURE: err = |exact − ax_sum|, unsigned WIDTH+1.
  - If err≠0: err_count+1, err_total+=err.
  - err_max = max(err_max, err). When err==0 the statistics are unchanged.
  - Sample counter increments.
  - If counter reaches n_samples go to DONE, else go to DRIVE.
- DONE: done=1 for one cycle, then IDLE. Statistics hold until the next accepted start or reset.
- start while not in IDLE is ignored, and so is start in the same cycle as rst.
- rst has priority over everything. It takes effect at the next edge, mid-run included.

## Timing
- Reset values:
  - state IDLE
  - busy 0, done 0
  - op_a 0, op_b 0, op_cin 0
  - err_count 0, err_total 0, err_max 0
  - LFSR=SEED
- Start accepted at edge 0:
  - DRIVE in cycle 1.
  - Sample k (1-based) is captured in cycle 2k.
  - DONE/done in cycle 2N+1.
  - busy deasserts in cycle 2N+2.
- n_samples==0: done in cycle 1, statistics all zero.
- ax_sum must be valid within the DRIVE cycle, because the adder is treated as combinational. It is sampled at the end of CAPTURE, so the adder gets two full cycles.
- Final statistics are valid in the done cycle and stay stable afterwards.

## Configuration
- ERR_MAX_EN defined: err_max tracking is compiled in as described.
- ERR_MAX_EN undefined: the comparator and register are removed, and err_max is tied to 0. All other behaviour and timing are identical.

## Structure
- Package adder_mon_pkg holds:
  - FSM state enum
  - LFSR polynomial constant (32'h8020_0003, Galois taps)
  - default SEED
  - helper function abs_diff
- One sub-module, lfsr32: ports clk, rst, load, seed, step, q.

## Test plan
- Exact adder wired to ax_sum, n_samples=100 → done in cycle 201; err_count 0, err_total 0, err_max 0.
- ax_sum = exact & ~17'h1 (LSB forced 0), n_samples=1000 → err_count equals the model's count of odd exact sums; err_total == err_count; err_max 1 (0 without ERR_MAX_EN).
- ax_sum = exact ^ 17'h10000, n_samples=10 → err_count 10, err_total 655360, err_max 65536.
- n_samples=0 → busy high and done pulse in cycle 1; all statistics 0.
- rst asserted at cycle 9 of a 20-sample run → next cycle IDLE with all outputs 0. A rerun from start reproduces the operand sequence and statistics of an uninterrupted run.
- start pulsed repeatedly while busy → no restart; done occurs exactly once, in cycle 2N+1 after the first start.
